// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer controller.
//   state_e   : FSM state encoding (ST_IDLE=0, ST_RUN=1)
//   MODE_*    : run-mode encodings latched on start
//   *_DEF     : default datapath widths
package timer_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PRE_WIDTH_DEF  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage : timer_pkg

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between CPU-side logic and the interval timer.
//   master : drives start/stop/mode/period/prescale/clr_done, observes status
//   slave  : the timer; observes controls, drives count/busy/tick/done/ovf
interface interval_timer_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRE_WIDTH  = 4
);

  logic                  start;
  logic                  stop;
  logic                  mode;
  logic [DATA_WIDTH-1:0] period;
  logic [PRE_WIDTH-1:0]  prescale;
  logic                  clr_done;
  logic [DATA_WIDTH-1:0] count;
  logic                  busy;
  logic                  tick;
  logic                  done;
  logic                  ovf;

  modport master (
    output start, stop, mode, period, prescale, clr_done,
    input  count, busy, tick, done, ovf
  );

  modport slave (
    input  start, stop, mode, period, prescale, clr_done,
    output count, busy, tick, done, ovf
  );

endinterface : interval_timer_ctrl_if

// File: rtl/timer_prescaler.sv
// Clock prescaler: strobes once every div+1 enabled cycles.
//   clk    : system clock
//   reset  : synchronous, active-low
//   en     : count enable; the internal counter is held at 0 while low
//   div    : divisor S
//   strobe : high in the cycle where the internal counter equals div
module timer_prescaler #(
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [PRE_WIDTH-1:0] div,
  output logic                 strobe
);

  logic [PRE_WIDTH-1:0] pre_q;

  // Strobe is a decode of the registered counter so the top can act on the
  // same edge that wraps the counter.
  assign strobe = en && (pre_q == div);

  // Divider counter: wraps to 0 on reaching div, cleared when disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q <= '0;
    end else if (!en) begin
      pre_q <= '0;
    end else if (pre_q == div) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_WIDTH'(1);
    end
  end

endmodule : timer_prescaler

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: one-shot / auto-reload with prescaler.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave side of interval_timer_ctrl_if
//           in : start, stop, mode, period, prescale, clr_done
//           out: count, busy, tick, done, ovf (all registered)
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PRE_WIDTH  = PRE_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  interval_timer_ctrl_if.slave bus
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] period_q;
  logic [PRE_WIDTH-1:0]  prescale_q;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] count_q;
  logic                  busy_q;
  logic                  tick_q;
  logic                  done_q;
  logic                  ovf_q;

  logic                  pre_en_c;
  logic                  pre_strobe;

  // Prescaler runs only in RUN; a stop clears it on the same edge as the FSM.
  assign pre_en_c = (state_q == ST_RUN) && !bus.stop;

  timer_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (pre_en_c),
    .div    (prescale_q),
    .strobe (pre_strobe)
  );

  // FSM, configuration latches, count register and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= MODE_ONESHOT;
      count_q    <= '0;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      tick_q <= 1'b0;

      // Clear first; an expiry later in this block overrides it.
      if (bus.clr_done) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.stop && (bus.period != '0)) begin
            period_q   <= bus.period;
            prescale_q <= bus.prescale;
            mode_q     <= bus.mode;
            count_q    <= '0;
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
          end else if (bus.stop) begin
            count_q <= '0;
          end
        end

        ST_RUN: begin
          if (bus.stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else if (pre_strobe) begin
            if (count_q != period_q) begin
              count_q <= count_q + DATA_WIDTH'(1);
            end else begin
              // Expiry: ovf looks at done before any same-edge clear.
              count_q <= '0;
              tick_q  <= 1'b1;
              done_q  <= 1'b1;
              ovf_q   <= done_q | (ovf_q & ~bus.clr_done);
              if (mode_q == MODE_ONESHOT) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;

endmodule : interval_timer_ctrl

// File: tb/tb_interval_timer_ctrl.sv
// Testbench for interval_timer_ctrl: directed scenarios plus randomized runs
// checked every cycle against an arithmetic reference model.
module tb_interval_timer_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 4;

  bit   clk = 1'b0;
  logic reset;

  interval_timer_ctrl_if #(.DATA_WIDTH(DW), .PRE_WIDTH(PW)) bus ();

  interval_timer_ctrl #(
    .DATA_WIDTH (DW),
    .PRE_WIDTH  (PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a run is described by k = edges since the start edge.
  // count = (k / (S+1)) mod (P+1); expiry when k is a multiple of (P+1)(S+1).
  bit m_run   = 1'b0;
  int m_k     = 0;
  int m_p     = 0;
  int m_s     = 0;
  bit m_mode  = 1'b0;
  int m_count = 0;
  bit m_tick  = 1'b0;
  bit m_done  = 1'b0;
  bit m_ovf   = 1'b0;
  bit prev_tick = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.clr_done = 1'b0;
  endtask

  // One clock: capture inputs, advance the model, compare all outputs.
  task automatic step();
    bit r, st, sp, md, cl, ev;
    int pd, ps, len;
    r  = reset;
    st = bus.start;
    sp = bus.stop;
    md = bus.mode;
    cl = bus.clr_done;
    pd = int'(bus.period);
    ps = int'(bus.prescale);
    ev = 1'b0;
    @(posedge clk);
    #1;
    if (!r) begin
      m_run = 0; m_k = 0; m_p = 0; m_s = 0; m_mode = 0;
      m_count = 0; m_tick = 0; m_done = 0; m_ovf = 0;
    end else begin
      if (m_run) begin
        if (sp) begin
          m_run   = 0;
          m_count = 0;
        end else begin
          m_k++;
          len     = (m_p + 1) * (m_s + 1);
          m_count = (m_k / (m_s + 1)) % (m_p + 1);
          if (m_k % len == 0) begin
            ev = 1'b1;
            if (!m_mode) m_run = 0;
          end
        end
      end else if (st && !sp && pd != 0) begin
        m_run = 1; m_k = 0; m_p = pd; m_s = ps; m_mode = md; m_count = 0;
      end else begin
        m_count = 0;
      end
      m_ovf  = (cl ? 1'b0 : m_ovf) | (ev & m_done);
      m_done = ev | (cl ? 1'b0 : m_done);
      m_tick = ev;
    end
    chk("count", 32'(bus.count), 32'(m_count));
    chk("busy",  32'(bus.busy),  32'(m_run));
    chk("tick",  32'(bus.tick),  32'(m_tick));
    chk("done",  32'(bus.done),  32'(m_done));
    chk("ovf",   32'(bus.ovf),   32'(m_ovf));
    if (m_run) chk("count_le_p", 32'(int'(bus.count) <= m_p), 32'd1);
    chk("tick_width", 32'(bus.tick && prev_tick), 32'd0);
    prev_tick = bus.tick;
  endtask

  task automatic start_run(input int p, input int s, input bit md);
    bus.period   = DW'(p);
    bus.prescale = PW'(s);
    bus.mode     = md;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.mode     = 1'b0;
    bus.period   = '0;
    bus.prescale = '0;
    bus.clr_done = 1'b0;

    // 1. Reset held with toggling inputs: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      bus.start    = 1'($urandom_range(0, 1));
      bus.stop     = 1'($urandom_range(0, 1));
      bus.mode     = 1'($urandom_range(0, 1));
      bus.clr_done = 1'($urandom_range(0, 1));
      bus.period   = DW'($urandom_range(1, 255));
      bus.prescale = PW'($urandom_range(0, 15));
      step();
    end
    reset = 1'b1;
    idle_in();
    step();

    // 2. One-shot P=3 S=0: tick after the 4th edge, busy falls, done set.
    start_run(3, 0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("os_tick", 32'(bus.tick), 32'd1);
    chk("os_busy", 32'(bus.busy), 32'd0);
    chk("os_done", 32'(bus.done), 32'd1);
    step();
    chk("os_tick_gone", 32'(bus.tick), 32'd0);
    bus.clr_done = 1'b1;
    step();
    bus.clr_done = 1'b0;

    // 3. Auto-reload P=2 S=1: tick every 6 clocks, ovf on 2nd, then clear.
    start_run(2, 1, 1'b1);
    for (int i = 0; i < 18; i++) step();
    chk("ar_tick3", 32'(bus.tick), 32'd1);
    chk("ar_ovf", 32'(bus.ovf), 32'd1);
    bus.clr_done = 1'b1;
    step();
    bus.clr_done = 1'b0;
    chk("ar_clr_done", 32'(bus.done), 32'd0);
    chk("ar_clr_ovf", 32'(bus.ovf), 32'd0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;

    // 4. start with period 0 ignored; start+stop together stays IDLE.
    start_run(0, 0, 1'b1);
    chk("p0_busy", 32'(bus.busy), 32'd0);
    bus.stop = 1'b1;
    start_run(5, 0, 1'b1);
    bus.stop = 1'b0;
    chk("ss_busy", 32'(bus.busy), 32'd0);
    step();

    // 5. stop at count=2 of P=7, then reset mid-run.
    start_run(7, 0, 1'b1);
    for (int i = 0; i < 20 && m_count != 2; i++) step();
    chk("reach_cnt2", 32'(bus.count), 32'd2);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_cnt", 32'(bus.count), 32'd0);
    start_run(3, 0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    step();

    // 6. clr_done on the expiry edge with done already 1; mid-run changes.
    start_run(1, 0, 1'b0);
    for (int i = 0; i < 2; i++) step();
    start_run(2, 0, 1'b0);
    step();
    step();
    bus.clr_done = 1'b1;
    step();
    bus.clr_done = 1'b0;
    chk("clr_vs_exp_done", 32'(bus.done), 32'd1);
    chk("clr_vs_exp_ovf", 32'(bus.ovf), 32'd1);
    start_run(3, 1, 1'b1);
    bus.period = DW'(9);
    bus.mode   = 1'b0;
    for (int i = 0; i < 24; i++) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;

    // Randomized runs with noisy inputs, clears and aborts.
    for (int r = 0; r < 20; r++) begin
      start_run(int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
      for (int c = 0; c < 40; c++) begin
        bus.clr_done = ($urandom_range(0, 7) == 0);
        bus.stop     = ($urandom_range(0, 59) == 0);
        bus.start    = ($urandom_range(0, 9) == 0);
        bus.mode     = 1'($urandom_range(0, 1));
        bus.period   = DW'($urandom_range(0, 12));
        bus.prescale = PW'($urandom_range(0, 3));
        step();
      end
      idle_in();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_interval_timer_ctrl
